// File: rtl/arcade_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// arcade_ctrl_pkg
// Shared definitions for the arcade control mapper: joystick word bit indices,
// the coin-shaper state encoding, counter widths and the opposing-direction
// (SOCD) cleaner used on the merged direction nibble.
// -----------------------------------------------------------------------------
package arcade_ctrl_pkg;

    // Bit positions inside a 16-bit joystick word
    localparam int unsigned JOY_R     = 0;
    localparam int unsigned JOY_L     = 1;
    localparam int unsigned JOY_D     = 2;
    localparam int unsigned JOY_U     = 3;
    localparam int unsigned JOY_BTN0  = 4;
    localparam int unsigned JOY_START = 12;
    localparam int unsigned JOY_COIN  = 13;

    // Counter widths
    localparam int unsigned COIN_CW = 16;
    localparam int unsigned AF_CW   = 20;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLD,
        GAP
    } coin_state_t;

    // Opposing directions pressed together cancel each other.
    function automatic logic [3:0] socd_clean(input logic [3:0] d);
        logic [3:0] c;
        c        = '0;
        c[JOY_U] = d[JOY_U] & ~d[JOY_D];
        c[JOY_D] = d[JOY_D] & ~d[JOY_U];
        c[JOY_L] = d[JOY_L] & ~d[JOY_R];
        c[JOY_R] = d[JOY_R] & ~d[JOY_L];
        return c;
    endfunction

endpackage

// File: rtl/arcade_coin_shaper.sv
// -----------------------------------------------------------------------------
// arcade_coin_shaper
// Turns a raw (active-high) coin button into a fixed-width, rate-limited,
// active-low coin pulse. A new rising edge is required for every pulse.
//
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset
//   coin_i   - raw coin request, active-high, same clock domain
//   coin_n_o - shaped coin output, active-low, registered
// -----------------------------------------------------------------------------
module arcade_coin_shaper
    import arcade_ctrl_pkg::*;
#(
    parameter int unsigned COIN_PULSE = 16'd2000,
    parameter int unsigned COIN_GAP   = 16'd4000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic coin_i,
    output logic coin_n_o
);

    localparam logic [COIN_CW-1:0] PULSE_LAST = COIN_CW'(COIN_PULSE - 1);
    localparam logic [COIN_CW-1:0] GAP_LAST   = COIN_CW'(COIN_GAP - 1);

    coin_state_t        state_q;
    logic [COIN_CW-1:0] cnt_q;
    logic               coin_prev_q;
    logic               coin_n_q;

    // coin_prev_q resets to 1 so a coin already held when reset is released
    // is not taken as a rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            coin_prev_q <= 1'b1;
            coin_n_q    <= 1'b1;
        end else begin
            coin_prev_q <= coin_i;
            unique case (state_q)
                IDLE: begin
                    if (coin_i && !coin_prev_q) begin
                        state_q  <= PULSE;
                        cnt_q    <= '0;
                        coin_n_q <= 1'b0;
                    end
                end
                PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q  <= HOLD;
                        cnt_q    <= '0;
                        coin_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (!coin_i) begin
                        state_q <= GAP;
                        cnt_q   <= '0;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    coin_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign coin_n_o = coin_n_q;

endmodule

// File: rtl/arcade_ctrl_mapper.sv
// -----------------------------------------------------------------------------
// arcade_ctrl_mapper
// Player-control front end for arcade cores. Per player: selects the USB or
// (synchronised) DB joystick word, merges all players in upright mode, cleans
// opposing directions, and shapes coin presses. All outputs are registered and
// active-low.
//
// Optional feature macro: ARCADE_CTRL_AUTOFIRE_EN -- when defined, af_en[p]
// turns button 0 of channel p into a square wave of AF_HALF-cycle half-period.
//
// Ports:
//   clk_sys   - clock
//   reset_n   - asynchronous active-low reset
//   joy_usb   - NUM_PLAYERS x 16-bit USB words (same domain)
//   joy_db    - NUM_PLAYERS x 16-bit DB words (asynchronous, synchronised here)
//   db_ports  - number of leading players sourced from joy_db
//   cocktail  - 0: all players ORed onto every channel, 1: separate channels
//   af_en     - per-player autofire enable on button 0
//   o_dir_n   - {U,D,L,R} per player, active-low
//   o_btn_n   - BTN_W buttons per player, active-low
//   o_start_n - start per player, active-low
//   o_coin_n  - shaped coin per player, active-low
// -----------------------------------------------------------------------------
module arcade_ctrl_mapper
    import arcade_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned BTN_W       = 2,
    parameter int unsigned COIN_PULSE  = 16'd2000,
    parameter int unsigned COIN_GAP    = 16'd4000,
    parameter int unsigned AF_HALF     = 20'd400000
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic [NUM_PLAYERS*16-1:0]    joy_usb,
    input  logic [NUM_PLAYERS*16-1:0]    joy_db,
    input  logic [2:0]                   db_ports,
    input  logic                         cocktail,
    input  logic [NUM_PLAYERS-1:0]       af_en,
    output logic [NUM_PLAYERS*4-1:0]     o_dir_n,
    output logic [NUM_PLAYERS*BTN_W-1:0] o_btn_n,
    output logic [NUM_PLAYERS-1:0]       o_start_n,
    output logic [NUM_PLAYERS-1:0]       o_coin_n
);

    // Elaboration-time configuration checks
    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_players
        $error("arcade_ctrl_mapper: NUM_PLAYERS must be 1..4");
    end
    if (BTN_W < 1 || BTN_W > 8) begin : g_bad_btn_w
        $error("arcade_ctrl_mapper: BTN_W must be 1..8");
    end
    if (COIN_PULSE < 1 || COIN_PULSE >= (1 << COIN_CW)) begin : g_bad_pulse
        $error("arcade_ctrl_mapper: COIN_PULSE out of range");
    end
    if (COIN_GAP < 1 || COIN_GAP >= (1 << COIN_CW)) begin : g_bad_gap
        $error("arcade_ctrl_mapper: COIN_GAP out of range");
    end
    if (AF_HALF < 1 || AF_HALF >= (1 << AF_CW)) begin : g_bad_af
        $error("arcade_ctrl_mapper: AF_HALF out of range");
    end

    logic [NUM_PLAYERS*16-1:0]          db_s1_q, db_s2_q;
    logic [NUM_PLAYERS-1:0][15:0]       sel_w;
    logic [15:0]                        or_w;
    logic [NUM_PLAYERS-1:0]             coin_w;
    logic [NUM_PLAYERS*4-1:0]           dir_d, dir_q;
    logic [NUM_PLAYERS*BTN_W-1:0]       btn_d, btn_q;
    logic [NUM_PLAYERS-1:0]             start_d, start_q;

`ifdef ARCADE_CTRL_AUTOFIRE_EN
    localparam logic [AF_CW-1:0] AF_LAST = AF_CW'(AF_HALF - 1);
    logic [AF_CW-1:0]       af_cnt_q [NUM_PLAYERS];
    logic [AF_CW-1:0]       af_cnt_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] af_ph_q, af_ph_d;
`else
    logic unused_af;
    assign unused_af = ^af_en;
`endif

    // Bits outside the used fields (and the merged coin bit) are don't-care.
    logic unused_bits;
    assign unused_bits = ^{sel_w, or_w};

    always_comb begin
        logic [3:0]       dir;
        logic [BTN_W-1:0] b;
        logic             st;
        or_w    = '0;
        sel_w   = '0;
        coin_w  = '0;
        dir_d   = '0;
        btn_d   = '0;
        start_d = '0;
        dir     = '0;
        b       = '0;
        st      = 1'b0;
`ifdef ARCADE_CTRL_AUTOFIRE_EN
        af_ph_d = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            af_cnt_d[p] = '0;
        end
`endif
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            sel_w[p]  = (p < 32'(db_ports)) ? db_s2_q[p*16 +: 16] : joy_usb[p*16 +: 16];
            or_w      = or_w | sel_w[p];
            coin_w[p] = sel_w[p][JOY_COIN];
        end
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            dir = cocktail ? sel_w[p][3:0]                  : or_w[3:0];
            b   = cocktail ? sel_w[p][JOY_BTN0 +: BTN_W]    : or_w[JOY_BTN0 +: BTN_W];
            st  = cocktail ? sel_w[p][JOY_START]            : or_w[JOY_START];
`ifdef ARCADE_CTRL_AUTOFIRE_EN
            // Phase 0 means asserted; releasing the button clears the phase.
            if (af_en[p] && b[0]) begin
                if (af_cnt_q[p] == AF_LAST) begin
                    af_cnt_d[p] = '0;
                    af_ph_d[p]  = ~af_ph_q[p];
                end else begin
                    af_cnt_d[p] = af_cnt_q[p] + 1'b1;
                    af_ph_d[p]  = af_ph_q[p];
                end
                b[0] = ~af_ph_q[p];
            end
`endif
            dir_d[p*4 +: 4]         = socd_clean(dir);
            btn_d[p*BTN_W +: BTN_W] = b;
            start_d[p]              = st;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            db_s1_q <= '0;
            db_s2_q <= '0;
            dir_q   <= '1;
            btn_q   <= '1;
            start_q <= '1;
        end else begin
            db_s1_q <= joy_db;
            db_s2_q <= db_s1_q;
            dir_q   <= ~dir_d;
            btn_q   <= ~btn_d;
            start_q <= ~start_d;
        end
    end

`ifdef ARCADE_CTRL_AUTOFIRE_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_ph_q <= '0;
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                af_cnt_q[p] <= '0;
            end
        end else begin
            af_ph_q <= af_ph_d;
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                af_cnt_q[p] <= af_cnt_d[p];
            end
        end
    end
`endif

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
        arcade_coin_shaper #(
            .COIN_PULSE (COIN_PULSE),
            .COIN_GAP   (COIN_GAP)
        ) u_coin (
            .clk_i    (clk_sys),
            .rst_ni   (reset_n),
            .coin_i   (coin_w[p]),
            .coin_n_o (o_coin_n[p])
        );
    end

    assign o_dir_n   = dir_q;
    assign o_btn_n   = btn_q;
    assign o_start_n = start_q;

endmodule

// File: tb/tb_arcade_ctrl_mapper.sv
// -----------------------------------------------------------------------------
// tb_arcade_ctrl_mapper
// Directed self-checking bench for arcade_ctrl_mapper with two players, two
// buttons, COIN_PULSE=4, COIN_GAP=3, AF_HALF=5.
// -----------------------------------------------------------------------------
module tb_arcade_ctrl_mapper;

    localparam int unsigned NP = 2;
    localparam int unsigned BW = 2;

    logic               clk_sys = 1'b0;
    logic               reset_n = 1'b0;
    logic [NP*16-1:0]   joy_usb;
    logic [NP*16-1:0]   joy_db;
    logic [2:0]         db_ports;
    logic               cocktail;
    logic [NP-1:0]      af_en;
    logic [NP*4-1:0]    o_dir_n;
    logic [NP*BW-1:0]   o_btn_n;
    logic [NP-1:0]      o_start_n;
    logic [NP-1:0]      o_coin_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_ctrl_mapper #(
        .NUM_PLAYERS (NP),
        .BTN_W       (BW),
        .COIN_PULSE  (4),
        .COIN_GAP    (3),
        .AF_HALF     (5)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .joy_usb   (joy_usb),
        .joy_db    (joy_db),
        .db_ports  (db_ports),
        .cocktail  (cocktail),
        .af_en     (af_en),
        .o_dir_n   (o_dir_n),
        .o_btn_n   (o_btn_n),
        .o_start_n (o_start_n),
        .o_coin_n  (o_coin_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Runs n cycles, counting low cycles of player 0's coin and noting the
    // first cycle (1-based) on which it was low.
    task automatic coin_run(input int n, output int lows, output int first);
        lows  = 0;
        first = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (o_coin_n[0] == 1'b0) begin
                lows++;
                if (first < 0) first = i;
            end
        end
    endtask

    initial begin
        int lows;
        int first;
        int errs;
        int p2_low;

        // ---------------- reset ----------------
        joy_usb  = '1;
        joy_db   = '1;
        db_ports = 3'd7;
        cocktail = 1'b0;
        af_en    = '1;
        reset_n  = 1'b0;
        ticks(3);
        check_eq("rst_dir",   32'(o_dir_n),   32'hFF);
        check_eq("rst_btn",   32'(o_btn_n),   32'hF);
        check_eq("rst_start", 32'(o_start_n), 32'h3);
        check_eq("rst_coin",  32'(o_coin_n),  32'h3);

        db_ports = 3'd0;
        cocktail = 1'b1;
        af_en    = '0;
        joy_db   = '0;
        joy_usb  = 32'h2000_2000;   // both coins held through release
        tick();
        reset_n = 1'b1;
        coin_run(8, lows, first);
        check_eq("rst_held_coin_lows", 32'(lows), 32'd0);
        check_eq("rst_held_coin_p2",   32'(o_coin_n), 32'h3);

        // ---------------- coin shaping ----------------
        cocktail = 1'b0;            // coin must stay per-player even when merged
        joy_usb  = '0;
        ticks(3);
        joy_usb[13] = 1'b1;
        lows = 0;
        first = -1;
        p2_low = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (o_coin_n[0] == 1'b0) begin
                lows++;
                if (first < 0) first = i;
            end
            if (o_coin_n[1] == 1'b0) p2_low++;
        end
        check_eq("coin_first_low", 32'(first), 32'd1);
        check_eq("coin_lows",      32'(lows),  32'd4);
        check_eq("coin_p2_quiet",  32'(p2_low), 32'd0);

        joy_usb[13] = 1'b0;
        ticks(2);
        joy_usb[13] = 1'b1;
        coin_run(10, lows, first);
        check_eq("coin_ignored_in_gap", 32'(lows), 32'd0);

        joy_usb[13] = 1'b0;
        ticks(2);
        joy_usb[13] = 1'b1;
        coin_run(8, lows, first);
        check_eq("coin_repress", 32'(lows), 32'd4);
        joy_usb[13] = 1'b0;
        ticks(4);
        joy_usb[13] = 1'b1;
        coin_run(8, lows, first);
        check_eq("coin_after_gap_lows",  32'(lows),  32'd4);
        check_eq("coin_after_gap_first", 32'(first), 32'd1);

        // reset in the middle of a pulse
        joy_usb[13] = 1'b0;
        ticks(8);
        joy_usb[13] = 1'b1;
        ticks(2);
        check_eq("coin_low_before_rst", 32'(o_coin_n[0]), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("coin_async_rst", 32'(o_coin_n[0]), 32'd1);
        tick();
        reset_n = 1'b1;
        coin_run(8, lows, first);
        check_eq("coin_no_fire_after_rst", 32'(lows), 32'd0);

        // ---------------- merge ----------------
        joy_usb  = '0;
        db_ports = 3'd0;
        cocktail = 1'b0;
        tick();
        joy_usb[17] = 1'b1;         // P2 L
        joy_usb[21] = 1'b1;         // P2 button 1
        tick();
        check_eq("merge_dir", 32'(o_dir_n), 32'hDD);
        check_eq("merge_btn", 32'(o_btn_n), 32'h5);
        cocktail = 1'b1;
        tick();
        check_eq("sep_dir", 32'(o_dir_n), 32'hDF);
        check_eq("sep_btn", 32'(o_btn_n), 32'h7);

        joy_usb = '0;
        joy_usb[28] = 1'b1;         // P2 start
        tick();
        check_eq("sep_start", 32'(o_start_n), 32'h1);
        cocktail = 1'b0;
        tick();
        check_eq("merge_start", 32'(o_start_n), 32'h0);

        // ---------------- source select ----------------
        cocktail = 1'b1;
        joy_usb  = '0;
        joy_usb[2] = 1'b1;          // P1 USB D
        joy_db   = '0;
        joy_db[3] = 1'b1;           // P1 DB U
        db_ports = 3'd1;
        tick();
        check_eq("db_lat1", 32'(o_dir_n[3:0]), 32'hF);
        tick();
        check_eq("db_lat2", 32'(o_dir_n[3:0]), 32'hF);
        tick();
        check_eq("db_lat3", 32'(o_dir_n[3:0]), 32'h7);
        db_ports = 3'd0;
        tick();
        check_eq("usb_after_switch", 32'(o_dir_n[3:0]), 32'hB);

        joy_usb  = '0;
        joy_db   = '0;
        joy_db[16] = 1'b1;          // P2 DB R
        db_ports = 3'd7;
        ticks(3);
        check_eq("db_all_ports", 32'(o_dir_n), 32'hEF);

        // ---------------- SOCD ----------------
        db_ports = 3'd0;
        joy_db   = '0;
        joy_usb  = '0;
        joy_usb[3:0] = 4'b1101;     // U+D+R
        tick();
        check_eq("socd_ud", 32'(o_dir_n[3:0]), 32'hE);
        joy_usb[3:0] = 4'b1011;     // U+L+R
        tick();
        check_eq("socd_lr", 32'(o_dir_n[3:0]), 32'h7);
        joy_usb[3:0] = 4'b1111;
        tick();
        check_eq("socd_all", 32'(o_dir_n[3:0]), 32'hF);

        // ---------------- autofire / button 0 ----------------
        joy_usb = '0;
        ticks(2);
`ifdef ARCADE_CTRL_AUTOFIRE_EN
        af_en = 2'b01;
        joy_usb[4]  = 1'b1;         // P1 button 0
        joy_usb[20] = 1'b1;         // P2 button 0 (autofire off)
        errs = 0;
        p2_low = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_btn_n[0] !== (((i / 5) % 2) == 1)) errs++;
            if (o_btn_n[2] == 1'b0) p2_low++;
        end
        check_eq("af_pattern", 32'(errs),   32'd0);
        check_eq("af_p2_held", 32'(p2_low), 32'd30);
        joy_usb = '0;
        tick();
        check_eq("af_release", 32'(o_btn_n[0]), 32'd1);
        joy_usb[4] = 1'b1;
        tick();
        check_eq("af_restart_low", 32'(o_btn_n[0]), 32'd0);
`else
        af_en = '1;
        joy_usb[4] = 1'b1;
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_btn_n[0] !== 1'b0) errs++;
        end
        check_eq("btn0_passthrough", 32'(errs), 32'd0);
        joy_usb = '0;
        tick();
        check_eq("btn0_release", 32'(o_btn_n[0]), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
